serial_inc_arbiter: RTL and testbench

- Shares one bit-serial increment/negate datapath between two requesters.
- Arbitrates round-robin, accepts a WIDTH-bit word through a valid/ready handshake, and runs it LSB-first through a one-bit carry chain over WIDTH cycles.
- Returns the result with a valid/ready response handshake.
- Used wherever word-level +1 or two's-complement negation is needed without a parallel adder.

---
 rtl/serial_inc_arbiter.sv | 148 ++++++++++++++
 tb/tb_serial_inc_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_inc_arbiter.sv
// Round-robin arbiter in front of a shared LSB-first bit-serial increment/negate unit.
// Each accepted word takes WIDTH shift cycles, then is held on a valid/ready response port.
module serial_inc_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_op,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_op,
   input  logic [WIDTH-1:0] req1_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_carry,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             op_q, op_d;
   logic             id_q, id_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic             last_id_q, last_id_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             resp_carry_q, resp_carry_d;
   logic             busy_q, busy_d;

   logic             grant;
   logic             idle;
   logic             bit_in;

   // Round-robin pick: under contention the requester that did not own the last result wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_id_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign idle       = (state_q == IDLE);
   assign req0_ready = idle && !grant;
   assign req1_ready = idle && grant;

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      op_d         = op_q;
      id_d         = id_q;
      carry_d      = carry_q;
      count_d      = count_q;
      last_id_d    = last_id_q;
      bit_in       = op_q ? ~sr_q[0] : sr_q[0];

      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               sr_d    = grant ? req1_data : req0_data;
               op_d    = grant ? req1_op : req0_op;
               id_d    = grant;
               carry_d = 1'b1;
               count_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // One carry-chain bit per cycle; the sum enters at the MSB as the word shifts right.
            sr_d    = {bit_in ^ carry_q, sr_q[WIDTH-1:1]};
            carry_d = bit_in & carry_q;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               last_id_d = id_q;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Response outputs are registered from the next state so they are zero outside RESP.
      resp_valid_d = (state_d == RESP);
      resp_id_d    = resp_valid_d ? id_d : 1'b0;
      resp_data_d  = resp_valid_d ? sr_d : '0;
      resp_carry_d = resp_valid_d ? carry_d : 1'b0;
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         op_q         <= 1'b0;
         id_q         <= 1'b0;
         carry_q      <= 1'b0;
         count_q      <= '0;
         last_id_q    <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_carry_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         op_q         <= op_d;
         id_q         <= id_d;
         carry_q      <= carry_d;
         count_q      <= count_d;
         last_id_q    <= last_id_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_carry_q <= resp_carry_d;
         busy_q       <= busy_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_carry = resp_carry_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_inc_arbiter.sv
// Directed bench for serial_inc_arbiter: arithmetic model, latency, hold, round-robin and abort.
module tb_serial_inc_arbiter;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req0_ready, req0_op;
   logic [WIDTH-1:0] req0_data;
   logic             req1_valid, req1_ready, req1_op;
   logic [WIDTH-1:0] req1_data;
   logic             resp_valid, resp_ready, resp_id, resp_carry, busy;
   logic [WIDTH-1:0] resp_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] data;
      logic             carry;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_inc_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_data  (req1_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_carry (resp_carry),
      .busy       (busy)
   );

   function automatic exp_t model(input logic id, input logic op, input logic [WIDTH-1:0] x);
      logic [WIDTH:0] s;
      s = {1'b0, (op ? ~x : x)} + (WIDTH + 1)'(1);
      return {id, s[WIDTH-1:0], s[WIDTH]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_data"},  32'(resp_data),  32'd0);
      chk({tag, "_id"},    32'(resp_id),    32'd0);
      chk({tag, "_carry"}, 32'(resp_carry), 32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
   endtask

   // Called at a negedge in IDLE: offers one request, confirms acceptance, returns at negedge N+1.
   task automatic accept(input logic id, input logic op, input logic [WIDTH-1:0] d);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_data = d;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_data = d;
      end
      #1;
      chk("acc_ready", 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
      sb.push_back(model(id, op, d));
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data  = ~req0_data; req1_data = ~req1_data;
   endtask

   // Starts at negedge N+1; checks the SHIFT window, the response, an optional stall, and the release.
   task automatic expect_resp(input int hold);
      exp_t e;
      for (int k = 1; k <= int'(WIDTH); k++) begin
         chk("shift_busy",  32'(busy), 32'd1);
         chk("shift_valid", 32'(resp_valid), 32'd0);
         chk("shift_rdy",   32'({req1_ready, req0_ready}), 32'd0);
         @(negedge clk);
      end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_busy",  32'(busy), 32'd1);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      chk("resp_id",    32'(resp_id),    32'(e.id));
      chk("resp_data",  32'(resp_data),  32'(e.data));
      chk("resp_carry", 32'(resp_carry), 32'(e.carry));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_id",    32'(resp_id),    32'(e.id));
         chk("hold_data",  32'(resp_data),  32'(e.data));
         chk("hold_carry", 32'(resp_carry), 32'(e.carry));
         chk("hold_rdy",   32'({req1_ready, req0_ready}), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check_idle_outputs("post");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      logic gid;
      int   prev;
      exp_t e;

      reset = 1'b1; resp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0;
      req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("reset");

      accept(1'b0, 1'b0, 4'b0101); expect_resp(0);
      accept(1'b1, 1'b1, 4'b0011); expect_resp(0);
      accept(1'b1, 1'b1, 4'b0000); expect_resp(0);
      accept(1'b0, 1'b0, 4'b1111); expect_resp(0);
      accept(1'b0, 1'b0, 4'b0111); expect_resp(0);
      accept(1'b1, 1'b0, 4'b1010); expect_resp(3);

      // Both requesters pending with the consumer always ready: grants alternate back to back.
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 1'b0; req0_data = 4'b0010;
      req1_valid = 1'b1; req1_op = 1'b1; req1_data = 4'b0100;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            #1;
            if (req0_ready || req1_ready) got = 1'b1;
            else @(negedge clk);
         end
         if (!got) chk("rr_accept_timeout", 32'd0, 32'd1);
         gid = req1_ready;
         chk("rr_order", 32'(gid), 32'(i % 2));
         if (i > 0) chk("rr_gap", 32'(cyc - prev), 32'(WIDTH + 2));
         prev = cyc;
         sb.push_back(model(gid, gid ? req1_op : req0_op, gid ? req1_data : req0_data));
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
         end
         if (!got) chk("rr_resp_timeout", 32'd0, 32'd1);
         e = (sb.size() != 0) ? sb.pop_front() : '0;
         chk("rr_id",    32'(resp_id),    32'(e.id));
         chk("rr_data",  32'(resp_data),  32'(e.data));
         chk("rr_carry", 32'(resp_carry), 32'(e.carry));
         if (i == 3) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      resp_ready = 1'b0;
      check_idle_outputs("rr_end");

      // Leave last_id at 0, then abort a req1 operation with reset mid-shift.
      accept(1'b0, 1'b0, 4'b0001); expect_resp(0);
      accept(1'b1, 1'b1, 4'b0110);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      if (sb.size() != 0) void'(sb.pop_back());
      check_idle_outputs("abort");
      got = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) got = 1'b1;
      end
      chk("abort_no_resp", 32'(got), 32'd0);

      req0_valid = 1'b1; req0_op = 1'b1; req0_data = 4'b1001;
      req1_valid = 1'b1; req1_op = 1'b0; req1_data = 4'b1110;
      #1;
      chk("post_reset_grant", 32'({req1_ready, req0_ready}), 32'd1);
      sb.push_back(model(1'b0, 1'b1, 4'b1001));
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      expect_resp(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
